// File: rtl/frame_pkg.sv
// frame_pkg: shared state encoding, frame defaults and counter helper for frame_assembler.
package frame_pkg;
  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHECK, S_DISCARD} state_t;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int MAX_LEN_DEFAULT = 16;
  localparam int CHK_W = 8;
  function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic inc);
    return c + 8'(inc && c != 8'hFF);
  endfunction
endpackage

// File: rtl/commit_fifo.sv
// commit_fifo: byte FIFO whose writes stay invisible until committed; rollback discards them.
module commit_fifo #(
  parameter int DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  input  logic       commit,
  input  logic       rollback,
  input  logic       rd_ready,
  output logic       full,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       rd_last
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, cm_ptr, rd_ptr;
  logic [8:0] mem [DEPTH];
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_valid = rd_ptr != cm_ptr;
  assign {rd_last, rd_data} = rd_valid ? mem[rd_ptr[AW-1:0]] : 9'h0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      cm_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= rollback ? cm_ptr : wr_ptr + (AW+1)'(wr_en && !full);
      if (commit) cm_ptr <= wr_ptr;
      if (rd_valid && rd_ready) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= {wr_last, wr_data};
endmodule

// File: rtl/frame_assembler.sv
// frame_assembler: hunts SYNC-framed, checksummed byte frames and forwards only verified payloads.
module frame_assembler
  import frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = SYNC_DEFAULT,
  parameter int         MAX_LEN    = MAX_LEN_DEFAULT,
  parameter int         FIFO_DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [7:0] ok_cnt,
  output logic [7:0] err_cnt,
  output logic [7:0] drop_cnt
);
  state_t state, nxt;
  logic [7:0] rem;
  logic [CHK_W-1:0] chk;
  logic full, legal, match, wr_en, wr_last, commit, rollback, err_inc, drop_inc;
  assign legal = in_data != 8'd0 && in_data <= 8'(MAX_LEN);
  assign match = in_data == chk;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_HUNT;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (in_valid)
      case (state)
        S_HUNT:    nxt = in_data == SYNC_BYTE ? S_LEN : S_HUNT;
        S_LEN:     nxt = legal ? S_PAYLOAD : S_HUNT;
        S_PAYLOAD: nxt = full ? S_DISCARD : rem == 8'd1 ? S_CHECK : S_PAYLOAD;
        S_CHECK:   nxt = S_HUNT;
        S_DISCARD: nxt = rem == 8'd1 ? S_HUNT : S_DISCARD;
        default:   nxt = S_HUNT;
      endcase
  end
  always_comb begin
    wr_en    = in_valid && state == S_PAYLOAD && !full;
    wr_last  = rem == 8'd1;
    commit   = in_valid && state == S_CHECK && match;
    drop_inc = in_valid && state == S_PAYLOAD && full;
    rollback = drop_inc || (in_valid && state == S_CHECK && !match);
    err_inc  = in_valid && ((state == S_LEN && !legal) || (state == S_CHECK && !match));
  end
  // On overflow rem is left as-is: it then counts the unread payload bytes plus CHK.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem      <= '0;
      chk      <= '0;
      ok_cnt   <= '0;
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (in_valid && state == S_LEN && legal) begin
        rem <= in_data;
        chk <= in_data;
      end
      if (wr_en) begin
        rem <= rem - 8'd1;
        chk <= chk + in_data;
      end
      if (in_valid && state == S_DISCARD) rem <= rem - 8'd1;
      ok_cnt   <= sat_inc(ok_cnt, commit);
      err_cnt  <= sat_inc(err_cnt, err_inc);
      drop_cnt <= sat_inc(drop_cnt, drop_inc);
    end
  commit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_data(in_data),
    .wr_last(wr_last),
    .commit(commit),
    .rollback(rollback),
    .rd_ready(out_ready),
    .full(full),
    .rd_valid(out_valid),
    .rd_data(out_data),
    .rd_last(out_last)
  );
endmodule

// File: doc/frame_assembler.md
FRAME_ASSEMBLER -- requirements
Module: frame_assembler

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 The block SHALL have parameter MAX_LEN, default 16, largest legal payload length in bytes.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 32 (power of two, >= MAX_LEN), output byte FIFO entries.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  in_data carries a byte this cycle; there is no backpressure toward the upstream byte source.
REQ-007 in_data  input  8  byte from the upstream byte source.
REQ-008 out_valid  output  1  out_data/out_last hold a committed payload byte.
REQ-009 out_ready  input  1  downstream accepts the byte when out_valid && out_ready.
REQ-010 out_data  output  8  payload byte.
REQ-011 out_last  output  1  marks the final payload byte of a frame.
REQ-012 ok_cnt, err_cnt, drop_cnt  output  8 each  saturating counts of good frames, bad frames (length/checksum), and overflow-dropped frames.

Function
REQ-013 Frame format SHALL be: SYNC_BYTE, LEN (1..MAX_LEN), LEN payload bytes, CHK, where CHK = (LEN + sum of payload) mod 256.
REQ-014 The FSM SHALL have states HUNT, LEN, PAYLOAD, CHECK, DISCARD; it SHALL advance only on cycles with in_valid=1.
REQ-015 HUNT: byte == SYNC_BYTE -> LEN; any other byte is ignored.
REQ-016 LEN: 1 <= byte <= MAX_LEN -> load remaining-count and seed checksum with byte, go PAYLOAD; otherwise increment err_cnt, go HUNT.
REQ-017 PAYLOAD: each byte SHALL be written speculatively at the speculative write pointer, added to the checksum, with last=1 on the final byte; after the final byte -> CHECK.
REQ-018 CHECK: byte == checksum -> commit (commit pointer := speculative pointer), increment ok_cnt; else roll back (speculative pointer := commit pointer), increment err_cnt; both go HUNT.
REQ-019 Overflow: a PAYLOAD byte arriving when speculative occupancy == FIFO_DEPTH SHALL roll back, increment drop_cnt, and go DISCARD with the remaining payload-plus-CHK byte count.
REQ-020 DISCARD SHALL consume the remaining bytes of the frame without writing, then go HUNT; SYNC_BYTE values inside it are not treated as frame starts.
REQ-021 out_valid SHALL be 1 when read pointer != commit pointer; uncommitted bytes are never visible.
REQ-022 out_data/out_last SHALL be read combinationally from the entry at the read pointer; the read pointer advances on out_valid && out_ready.
REQ-023 The first byte of a frame SHALL appear on out_valid in the cycle after its CHK byte is accepted (1-cycle latency from CHK).
REQ-024 A read and a write/commit/rollback in the same cycle SHALL both take effect; occupancy uses read pointer as it was before the read.
REQ-025 Pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full/empty are decided by the extra MSB.
REQ-026 Counters SHALL saturate at 8'hFF.

Reset
REQ-027 On rst_n=0, the FSM SHALL go to HUNT; all pointers, checksum, remaining-count and counters SHALL clear; out_valid=0, out_last=0, out_data=8'h00.
REQ-028 Reset mid-frame SHALL discard all committed and speculative data; the first post-reset frame needs a fresh SYNC_BYTE.

Structure
REQ-029 A shared package frame_pkg SHALL hold the state encoding, SYNC_BYTE/MAX_LEN defaults and the checksum width.
REQ-030 The FIFO with speculative write, commit and rollback SHALL be a sub-module named commit_fifo; frame_assembler holds the FSM, checksum and counters.

Verification
REQ-031 Good frame: A5 03 10 20 30 63, out_ready=1 -> out 10,20,30 with out_last on 30, ok_cnt=1, first byte the cycle after 63.
REQ-032 Bad checksum: A5 02 11 22 00 -> no output, err_cnt=1; following A5 01 7F 80 -> out 7F last, ok_cnt=1.
REQ-033 Illegal length: A5 00 and A5 11 (MAX_LEN=16) -> err_cnt=2, no writes, FSM in HUNT.
REQ-034 Overflow: out_ready=0, two good 16-byte frames commit (32 entries), third A5 10 ... frame -> drop_cnt=1, exactly 32 bytes then drain, embedded A5 in dropped payload ignored.
REQ-035 Simultaneous: out_ready=1 while a CHK commits and a byte is read in the same cycle -> no loss, no duplication, in-order output across pointer wrap (>=3 full passes of FIFO_DEPTH).
REQ-036 Reset mid-PAYLOAD of A5 04 01 02 -> out_valid=0, counters 0; next A5 01 55 56 -> out 55 last.
